// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, addresses a sync-read imem, hands words to decode.
// Latency: word issued at edge E is captured at E+1; first word valid two edges after reset drops.
// Backpressure: output register plus one skid entry; issue stalls whenever a new read could not be stored.
module fetch_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  halt,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nxt;
    logic                    issue;

    logic [ADDR_WIDTH-1:0]   pc;
    logic                    fl_vld;     // a read is in flight; data arrives this cycle
    logic [ADDR_WIDTH-1:0]   fl_pc;
    logic                    out_vld;
    logic [DATA_WIDTH-1:0]   out_dat;
    logic [ADDR_WIDTH-1:0]   out_pc;
    logic                    skid_vld;
    logic [DATA_WIDTH-1:0]   skid_dat;
    logic [ADDR_WIDTH-1:0]   skid_pc;

    logic                    out_keep;   // output register stays occupied across this edge
    logic [1:0]              occ;        // storage committed after this edge, before a new read
    logic                    room;

    assign out_keep = out_vld && !instr_ready;
    assign occ      = {1'b0, out_keep} + {1'b0, skid_vld} + {1'b0, fl_vld};
    assign room     = (occ <= 2'd1);

    assign imem_addr   = pc;
    assign instr       = out_dat;
    assign instr_pc    = out_pc;
    assign instr_valid = out_vld;

    // Mode register: RUN / STALL / HALTED.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next mode and issue decision; a redirect overrides everything and never issues.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        if (redirect_valid) begin
            state_nxt = halt ? HALTED : RUN;
        end else begin
            case (state)
                HALTED: begin
                    if (!halt) begin
                        issue     = room;
                        state_nxt = room ? RUN : STALL;
                    end
                end
                default: begin
                    if (halt) begin
                        state_nxt = HALTED;
                    end else begin
                        issue     = room;
                        state_nxt = room ? RUN : STALL;
                    end
                end
            endcase
        end
    end

    // PC, in-flight tracking, output register and skid buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            fl_vld   <= 1'b0;
            fl_pc    <= '0;
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_pc   <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
            skid_pc  <= '0;
        end else if (redirect_valid) begin
            // Squash the pending read and drop everything buffered; any transfer
            // on this edge has already been taken by decode.
            pc       <= redirect_addr;
            fl_vld   <= 1'b0;
            skid_vld <= 1'b0;
            out_vld  <= 1'b0;
        end else begin
            fl_vld <= issue;
            if (issue) begin
                fl_pc <= pc;
                pc    <= pc + PC_ONE;
            end
            if (!out_keep) begin
                // Output register frees up: oldest word (skid first) moves in.
                if (skid_vld) begin
                    out_vld  <= 1'b1;
                    out_dat  <= skid_dat;
                    out_pc   <= skid_pc;
                    skid_vld <= fl_vld;
                    if (fl_vld) begin
                        skid_dat <= imem_data;
                        skid_pc  <= fl_pc;
                    end
                end else if (fl_vld) begin
                    out_vld <= 1'b1;
                    out_dat <= imem_data;
                    out_pc  <= fl_pc;
                end else begin
                    out_vld <= 1'b0;
                end
            end else if (fl_vld) begin
                // Output held by backpressure: the arriving word parks in the skid entry.
                skid_vld <= 1'b1;
                skid_dat <= imem_data;
                skid_pc  <= fl_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: queue-based reference model checked every cycle, plus directed scenarios.
// Inputs are driven on the falling edge; the model compares one time unit after each rising edge.
// A second instance with RESET_PC=1022 exercises PC wrap-around.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [9:0]  redirect_addr;
    logic        halt;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic [9:0]  imem_addr2;
    logic [31:0] imem_data2;
    logic [31:0] instr2;
    logic [9:0]  instr_pc2;
    logic        instr_valid2;

    int checks = 0;
    int fails  = 0;

    fetch_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RESET_PC(10'd0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    fetch_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RESET_PC(10'd1022)) dut_wrap (
        .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .redirect_valid(1'b0), .redirect_addr(10'd0), .halt(1'b0),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ready(1'b1)
    );

    function automatic logic [31:0] word(input logic [9:0] a);
        return 32'h1000_0000 + {22'd0, a};
    endfunction

    // Synchronous-read instruction memories
    always @(posedge clk) begin
        imem_data  <= word(imem_addr);
        imem_data2 <= word(imem_addr2);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of word addresses held for decode (head = presented),
    // one optional in-flight read, and the next fetch address.
    logic [9:0] mq[$];
    logic [9:0] m_pc;
    logic [9:0] m_fl_pc;
    int         m_fl;
    bit         m_on = 0;

    initial begin
        bit xfer;
        bit iss;
        bit in_rst;
        forever begin
            @(posedge clk);
            in_rst = reset;
            if (reset) begin
                m_pc  = 10'd0;
                m_fl  = 0;
                mq.delete();
                m_on  = 1;
            end else if (m_on) begin
                xfer = (mq.size() > 0) && instr_ready;
                if (redirect_valid) begin
                    mq.delete();
                    m_fl = 0;
                    m_pc = redirect_addr;
                end else begin
                    if (xfer) void'(mq.pop_front());
                    iss = !halt && (mq.size() + m_fl <= 1);
                    if (m_fl != 0) mq.push_back(m_fl_pc);
                    m_fl    = iss ? 1 : 0;
                    m_fl_pc = m_pc;
                    if (iss) m_pc = m_pc + 10'd1;
                end
            end
            #1;
            if (m_on) begin
                chk("model_valid", {31'd0, instr_valid}, {31'd0, mq.size() > 0});
                chk("model_addr", {22'd0, imem_addr}, {22'd0, m_pc});
                if (mq.size() > 0) begin
                    chk("model_pc", {22'd0, instr_pc}, {22'd0, mq[0]});
                    chk("model_instr", instr, word(mq[0]));
                end
                if (in_rst) begin
                    chk("reset_instr", instr, 32'd0);
                    chk("reset_pc", {22'd0, instr_pc}, 32'd0);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait (bounded) until the given address is presented.
    task automatic wait_pc(input logic [9:0] p);
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == p) begin
                found = 1;
                break;
            end
        end
        chk($sformatf("wait_pc_%0d", p), {31'd0, found}, 32'd1);
    endtask

    // Next presented word (bounded); assumes instr_ready is high.
    task automatic next_valid(output logic [9:0] p);
        bit found = 0;
        p = 10'h3ff;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1;
                p = instr_pc;
                break;
            end
        end
        chk("next_valid_timeout", {31'd0, found}, 32'd1);
    endtask

    initial begin
        logic [9:0] p;
        logic [9:0] wrap_exp[4];
        logic [9:0] hold_addr;
        wrap_exp[0] = 10'd1022; wrap_exp[1] = 10'd1023; wrap_exp[2] = 10'd0; wrap_exp[3] = 10'd1;

        reset = 1'b1; redirect_valid = 1'b0; redirect_addr = '0; halt = 1'b0; instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_addr", {22'd0, imem_addr}, 32'd0);
        chk("rst_addr_wrap", {22'd0, imem_addr2}, 32'd1022);

        // Free-run streaming with wrap instance alongside
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("first_edge_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
                chk("stream_valid", {31'd0, instr_valid}, 32'd1);
                chk("stream_pc", {22'd0, instr_pc}, i - 1);
                chk("stream_instr", instr, 32'h1000_0000 + i - 1);
            end
            if (i >= 1 && i <= 4) begin
                chk("wrap_valid", {31'd0, instr_valid2}, 32'd1);
                chk("wrap_pc", {22'd0, instr_pc2}, {22'd0, wrap_exp[i-1]});
            end
        end

        // Backpressure while address 4 is presented
        do_reset();
        wait_pc(10'd4);
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_instr", instr, 32'h1000_0004);
            chk("bp_addr", {22'd0, imem_addr}, 32'd6);
        end
        instr_ready = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            @(negedge clk);
            chk("bp_release_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_release_pc", {22'd0, instr_pc}, i);
        end

        // Redirect while 3 is presented and 4 is in flight
        do_reset();
        wait_pc(10'd3);
        redirect_valid = 1'b1;
        redirect_addr  = 10'd200;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_bubble", {31'd0, instr_valid}, 32'd0);
        next_valid(p);
        chk("redir_first", {22'd0, p}, 32'd200);
        next_valid(p);
        chk("redir_second", {22'd0, p}, 32'd201);

        // Halt mid-stream
        do_reset();
        wait_pc(10'd6);
        halt = 1'b1;
        @(negedge clk);
        chk("halt_inflight_pc", {22'd0, instr_pc}, 32'd7);
        chk("halt_inflight_valid", {31'd0, instr_valid}, 32'd1);
        hold_addr = imem_addr;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_idle", {31'd0, instr_valid}, 32'd0);
            chk("halt_addr", {22'd0, imem_addr}, 32'd8);
        end
        chk("halt_addr_const", {22'd0, imem_addr}, {22'd0, hold_addr});
        halt = 1'b0;
        next_valid(p);
        chk("halt_resume", {22'd0, p}, 32'd8);
        next_valid(p);
        chk("halt_resume2", {22'd0, p}, 32'd9);
        halt = 1'b1;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_addr  = 10'd50;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        halt = 1'b0;
        next_valid(p);
        chk("halt_redirect", {22'd0, p}, 32'd50);

        // Reset while stalled with a valid word
        repeat (4) @(negedge clk);
        instr_ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", {31'd0, instr_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_pc", {22'd0, instr_pc}, 32'd0);
        chk("mid_rst_addr", {22'd0, imem_addr}, 32'd0);
        reset = 1'b0;
        instr_ready = 1'b1;
        next_valid(p);
        chk("restart_pc", {22'd0, p}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            instr_ready    = ($urandom_range(0, 3) != 0);
            halt           = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_addr  = 10'($urandom);
            reset          = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        reset = 1'b0; halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the CPU front end: owns the program counter and drives the synchronous-read instruction memory address.
- Tracks the one-cycle read latency and delivers each instruction with its word address to decode over a valid/ready handshake.
- Supports backpressure, branch/jump redirect with flush, halt, and PC wrap-around.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 10, word-address width of instruction memory
RESET_PC, 0, word address fetched first after reset

Ports:
clk  input  1  rising-edge clock shared with instruction memory
reset  input  1  synchronous, active-high reset
imem_addr  output  ADDR_WIDTH  word address to instruction memory; memory samples it on the rising clk edge
imem_data  input  DATA_WIDTH  memory read data; valid during the cycle after the address was sampled
redirect_valid  input  1  one-cycle pulse: discard pending fetches, continue at redirect_addr
redirect_addr  input  ADDR_WIDTH  redirect target word address
halt  input  1  level: while high, no new reads are issued
instr  output  DATA_WIDTH  delivered instruction
instr_pc  output  ADDR_WIDTH  word address of instr
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  decode accepts; transfer occurs on an edge where instr_valid && instr_ready

Behaviour:
- Reset, sampled on an edge with reset=1:
  - pc=RESET_PC; instr_valid=0; instr=0; instr_pc=0.
  - In-flight flag and skid entry cleared.
  - imem_addr=RESET_PC.
  - Reset takes priority over every other input, including mid-operation.
- Address issue:
  - imem_addr is driven from the pc register. A read is "issued" on an edge where the issue condition holds; pc then increments by 1 modulo 2^ADDR_WIDTH, so (2^ADDR_WIDTH-1) wraps to 0.
  - Issue condition: !halt && !redirect_valid && the read will have guaranteed storage.
  - Storage = output register plus a one-entry skid buffer. Issue only if (output occupancy after this edge's transfer) + skid occupancy + in-flight read <= 1 before the new read is counted.
- Latency:
  - A read issued at edge E has its data captured at edge E+1.
  - Captured data goes into the output register if that register is empty or transferring on E+1; otherwise it goes into the skid buffer.
  - After the first edge with reset=0, instr_valid=1 with instr_pc=RESET_PC one edge later.
- Throughput: with instr_ready held high and no halt/redirect, one instruction per cycle, consecutive instr_pc values.
- Backpressure:
  - While instr_valid && !instr_ready, instr and instr_pc stay stable.
  - At most one further word is absorbed, into the skid buffer; issue then stalls with pc unchanged.
  - When the stall releases, the skid entry is delivered next, in order. No word is dropped or duplicated.
- Redirect, on an edge with redirect_valid=1:
  - pc=redirect_addr.
  - In-flight read marked squashed; its data is never delivered.
  - Skid buffer emptied; instr_valid=0 after the edge, even if instr_ready was high. A transfer occurring on that same edge still counts as accepted.
  - The read of redirect_addr is issued on the following edge, or later if halt is high.
  - Redirect during halt updates pc only.
  - Back-to-back redirects: the last one wins.
- Halt:
  - Stops issue only; an already in-flight read still completes and is delivered.
  - Deasserting halt resumes issue at the current pc on the next edge.
- Internal states:
  - RUN: issuing.
  - STALL: storage full.
  - HALTED: halt=1.
  - Redirect is handled from any state; it returns to RUN, or to HALTED if halt is high.

Test Plan:
- Memory word[a]=32'h1000_0000+a. Reset 2 cycles, then instr_ready=1 for 30 cycles -> instr_valid rises 2 edges after reset drops; instr_pc 0,1,2,...; instr=32'h1000_0000+instr_pc; one instruction per cycle, no gaps.
- Free-run, then hold instr_ready=0 for 5 cycles while instr_pc=4 is presented -> instr stays 32'h1000_0004 and imem_addr stays at 6. On release, 4,5,6,7 are delivered with no loss or duplicate.
- Pulse redirect_valid with redirect_addr=10'd200 while instr_pc=3 is presented and the read of 4 is in flight -> instr_valid=0 for one cycle; next delivered instr_pc=200, then 201. Addresses 4 and 5 are never delivered.
- RESET_PC=10'd1022, free-run -> instr_pc sequence 1022, 1023, 0, 1.
- Assert halt for 4 cycles mid-stream -> the in-flight word is still delivered, then instr_valid=0 and imem_addr is constant. After release, the sequence continues at the next address with no gaps. Redirect to 50 during halt -> first word after release has instr_pc=50.
- Assert reset mid-stream while instr_valid=1 and instr_ready=0 -> after the edge, instr_valid=0, instr=0, instr_pc=0, imem_addr=RESET_PC. Sequence restarts from RESET_PC.
